// File: rtl/movimenta_objetos_multi_pkg.sv
// Shared constants for the multi-object mover: default resolution,
// colours, palette lookup and mode encoding.
package movimenta_objetos_multi_pkg;

  localparam int H_RES_DEF = 640;
  localparam int V_RES_DEF = 480;

  // SW[2] selects how objects move
  typedef enum logic {
    MODE_MANUAL = 1'b0,
    MODE_BOUNCE = 1'b1
  } mode_e;

  typedef struct packed {
    logic [7:0] r;
    logic [7:0] g;
    logic [7:0] b;
  } rgb_t;

  localparam rgb_t RGB_BLACK = rgb_t'(24'h000000);
  localparam rgb_t RGB_BG    = rgb_t'(24'h0000FF);
  localparam rgb_t RGB_SEL   = rgb_t'(24'hFFFFFF);

  // Per-object colour; index is the object number
  function automatic rgb_t palette(input logic [1:0] idx);
    case (idx)
      2'd0:    palette = rgb_t'(24'hFF0000);
      2'd1:    palette = rgb_t'(24'h00FF00);
      2'd2:    palette = rgb_t'(24'hFFFF00);
      default: palette = rgb_t'(24'hFF00FF);
    endcase
  endfunction

endpackage

// File: rtl/movimenta_objetos_multi_objeto_movel.sv
// One movable square: position/direction state, clamped stepping in
// both manual and bounce modes, and the pixel hit test.
module objeto_movel
  import movimenta_objetos_multi_pkg::*;
#(
  parameter int IDX      = 0,
  parameter int OBJ_SIZE = 50,
  parameter int STEP     = 2,
  parameter int H_RES    = H_RES_DEF,
  parameter int V_RES    = V_RES_DEF
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       tick_i,
  input  logic       bounce_i,
  input  logic       sel_i,
  input  logic       key_rt_i,
  input  logic       key_lf_i,
  input  logic       key_up_i,
  input  logic       key_dn_i,
  input  logic [9:0] col_i,
  input  logic [8:0] row_i,
  output logic       hit_o
);

  localparam logic [10:0] XMAX   = 11'(H_RES - OBJ_SIZE);
  localparam logic [9:0]  XMAX10 = 10'(H_RES - OBJ_SIZE);
  localparam logic [9:0]  YMAX   = 10'(V_RES - OBJ_SIZE);
  localparam logic [8:0]  YMAX9  = 9'(V_RES - OBJ_SIZE);
  localparam logic [9:0]  X_RST  = 10'(20 + IDX * (OBJ_SIZE + 20));
  localparam logic [8:0]  Y_RST  = 9'd150;

  logic [9:0]  x_q, x_d;
  logic [8:0]  y_q, y_d;
  logic        dx_q, dx_d, dy_q, dy_d;

  logic [10:0] x_sum;
  logic [9:0]  y_sum;
  logic [9:0]  x_up, x_dn;
  logic [8:0]  y_up, y_dn;

  // Clamped candidate positions one step up/down on each axis
  always_comb begin
    x_sum = {1'b0, x_q} + 11'(STEP);
    y_sum = {1'b0, y_q} + 10'(STEP);
    x_up  = (x_sum > XMAX) ? XMAX10 : x_sum[9:0];
    y_up  = (y_sum > YMAX) ? YMAX9  : y_sum[8:0];
    x_dn  = (x_q < 10'(STEP)) ? '0 : x_q - 10'(STEP);
    y_dn  = (y_q < 9'(STEP))  ? '0 : y_q - 9'(STEP);
  end

  // Next position/direction; only tick cycles change anything
  always_comb begin
    x_d  = x_q;
    y_d  = y_q;
    dx_d = dx_q;
    dy_d = dy_q;
    if (tick_i) begin
      if (bounce_i) begin
        x_d = dx_q ? x_up : x_dn;
        y_d = dy_q ? y_up : y_dn;
        // landing on (or clamping to) a wall reverses that axis
        if (dx_q && (x_up == XMAX10)) dx_d = 1'b0;
        if (!dx_q && (x_dn == '0))    dx_d = 1'b1;
        if (dy_q && (y_up == YMAX9))  dy_d = 1'b0;
        if (!dy_q && (y_dn == '0))    dy_d = 1'b1;
      end else if (sel_i) begin
        // opposing buttons cancel out
        if (key_rt_i && !key_lf_i)      x_d = x_up;
        else if (key_lf_i && !key_rt_i) x_d = x_dn;
        if (key_dn_i && !key_up_i)      y_d = y_up;
        else if (key_up_i && !key_dn_i) y_d = y_dn;
      end
    end
  end

  // Position and direction registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      x_q  <= X_RST;
      y_q  <= Y_RST;
      dx_q <= 1'b1;
      dy_q <= 1'b1;
    end else begin
      x_q  <= x_d;
      y_q  <= y_d;
      dx_q <= dx_d;
      dy_q <= dy_d;
    end
  end

  logic [10:0] x_end;
  logic [9:0]  y_end;

  // Pixel inside the square, widened so x+size cannot wrap
  always_comb begin
    x_end = {1'b0, x_q} + 11'(OBJ_SIZE);
    y_end = {1'b0, y_q} + 10'(OBJ_SIZE);
    hit_o = ({1'b0, col_i} >= {1'b0, x_q}) && ({1'b0, col_i} < x_end) &&
            ({1'b0, row_i} >= {1'b0, y_q}) && ({1'b0, row_i} < y_end);
  end

endmodule

// File: rtl/movimenta_objetos_multi.sv
// Top: motion tick generator, controlled-object selection, N_OBJ
// object instances, lowest-index-wins colour mux and output register.
module movimenta_objetos_multi
  import movimenta_objetos_multi_pkg::*;
#(
  parameter int N_OBJ    = 2,
  parameter int OBJ_SIZE = 50,
  parameter int STEP     = 2,
  parameter int TICK_DIV = 833333,
  parameter int H_RES    = H_RES_DEF,
  parameter int V_RES    = V_RES_DEF
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [9:0] col,
  input  logic [8:0] row,
  input  logic       disp_ena,
  input  logic [2:0] SW,
  input  logic [3:0] KEY,
  output logic [7:0] red,
  output logic [7:0] green,
  output logic [7:0] blue
);

  localparam int CW = $clog2(TICK_DIV);

  logic [CW-1:0] cnt_q, cnt_d;
  logic          tick;

  assign tick  = (cnt_q == CW'(TICK_DIV - 1));
  assign cnt_d = tick ? '0 : cnt_q + 1'b1;

  // Free-running motion tick divider
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) cnt_q <= '0;
    else          cnt_q <= cnt_d;
  end

  mode_e            mode;
  logic [N_OBJ-1:0] sel;
  logic [N_OBJ-1:0] hit;

  assign mode = mode_e'(SW[2]);

  for (genvar i = 0; i < N_OBJ; i++) begin : g_obj
    // a selector value past N_OBJ-1 matches no instance
    assign sel[i] = (mode == MODE_MANUAL) && (SW[1:0] == 2'(i));

    objeto_movel #(
      .IDX     (i),
      .OBJ_SIZE(OBJ_SIZE),
      .STEP    (STEP),
      .H_RES   (H_RES),
      .V_RES   (V_RES)
    ) u_obj (
      .clk     (clk),
      .reset_n (reset_n),
      .tick_i  (tick),
      .bounce_i(mode == MODE_BOUNCE),
      .sel_i   (sel[i]),
      .key_rt_i(~KEY[0]),
      .key_lf_i(~KEY[1]),
      .key_up_i(~KEY[2]),
      .key_dn_i(~KEY[3]),
      .col_i   (col),
      .row_i   (row),
      .hit_o   (hit[i])
    );
  end

  rgb_t pix_d, pix_q;

  // Colour select: scan high to low so the lowest index overrides
  always_comb begin
    pix_d = RGB_BG;
    for (int i = N_OBJ - 1; i >= 0; i--) begin
      if (hit[i]) pix_d = sel[i] ? RGB_SEL : palette(2'(i));
    end
    if (!disp_ena) pix_d = RGB_BLACK;
  end

  // One-cycle registered pixel output
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) pix_q <= RGB_BLACK;
    else          pix_q <= pix_d;
  end

  assign red   = pix_q.r;
  assign green = pix_q.g;
  assign blue  = pix_q.b;

endmodule

// File: tb/tb_movimenta_objetos_multi.sv
// Randomized bench for movimenta_objetos_multi with an integer-level
// reference model of positions, directions and pixel colour.
module tb_movimenta_objetos_multi;

  localparam int N_OBJ    = 2;
  localparam int OBJ_SIZE = 50;
  localparam int STEP     = 2;
  localparam int TICK_DIV = 4;
  localparam int H_RES    = 640;
  localparam int V_RES    = 480;
  localparam int XMAX     = H_RES - OBJ_SIZE;
  localparam int YMAX     = V_RES - OBJ_SIZE;
  localparam logic [23:0] PAL [4] = '{24'hFF0000, 24'h00FF00, 24'hFFFF00, 24'hFF00FF};

  logic       clk;
  logic       reset_n;
  logic [9:0] col;
  logic [8:0] row;
  logic       disp_ena;
  logic [2:0] SW;
  logic [3:0] KEY;
  logic [7:0] red, green, blue;

  movimenta_objetos_multi #(
    .N_OBJ(N_OBJ), .OBJ_SIZE(OBJ_SIZE), .STEP(STEP), .TICK_DIV(TICK_DIV),
    .H_RES(H_RES), .V_RES(V_RES)
  ) dut (
    .clk(clk), .reset_n(reset_n), .col(col), .row(row), .disp_ena(disp_ena),
    .SW(SW), .KEY(KEY), .red(red), .green(green), .blue(blue)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk = 0;
  int n_fail = 0;
  bit chk_en = 1'b0;

  // reference state
  int          mx [N_OBJ];
  int          my [N_OBJ];
  bit          mdx [N_OBJ];
  bit          mdy [N_OBJ];
  int          mcnt;
  int          mticks = 0;
  logic [23:0] exp_rgb;

  function automatic int clampi(int v, int hi);
    if (v < 0) return 0;
    if (v > hi) return hi;
    return v;
  endfunction

  function automatic bit flipped(int np, bit d, int hi);
    if (d && np == hi) return 1'b0;
    if (!d && np == 0) return 1'b1;
    return d;
  endfunction

  function automatic int kdelta(bit plus, bit minus);
    return (plus ? STEP : 0) - (minus ? STEP : 0);
  endfunction

  function automatic logic [23:0] model_rgb();
    logic [23:0] c;
    c = 24'h0000FF;
    for (int i = N_OBJ - 1; i >= 0; i--)
      if (int'(col) >= mx[i] && int'(col) < mx[i] + OBJ_SIZE &&
          int'(row) >= my[i] && int'(row) < my[i] + OBJ_SIZE)
        c = (!SW[2] && int'(SW[1:0]) == i) ? 24'hFFFFFF : PAL[i];
    if (!disp_ena) c = 24'h0;
    return c;
  endfunction

  // Reference model: colour from pre-edge positions, then tick motion
  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      mcnt    <= 0;
      exp_rgb <= 24'h0;
      for (int i = 0; i < N_OBJ; i++) begin
        mx[i] <= 20 + i * (OBJ_SIZE + 20);
        my[i] <= 150;
        mdx[i] <= 1'b1;
        mdy[i] <= 1'b1;
      end
    end else begin
      exp_rgb <= model_rgb();
      if (mcnt == TICK_DIV - 1) begin
        mcnt   <= 0;
        mticks <= mticks + 1;
        for (int i = 0; i < N_OBJ; i++) begin
          if (SW[2]) begin
            mx[i]  <= clampi(mx[i] + (mdx[i] ? STEP : -STEP), XMAX);
            my[i]  <= clampi(my[i] + (mdy[i] ? STEP : -STEP), YMAX);
            mdx[i] <= flipped(clampi(mx[i] + (mdx[i] ? STEP : -STEP), XMAX), mdx[i], XMAX);
            mdy[i] <= flipped(clampi(my[i] + (mdy[i] ? STEP : -STEP), YMAX), mdy[i], YMAX);
          end else if (int'(SW[1:0]) == i) begin
            mx[i] <= clampi(mx[i] + kdelta(!KEY[0], !KEY[1]), XMAX);
            my[i] <= clampi(my[i] + kdelta(!KEY[3], !KEY[2]), YMAX);
          end
        end
      end else begin
        mcnt <= mcnt + 1;
      end
    end
  end

  // Per-cycle output comparison against the model
  always @(negedge clk) begin
    if (chk_en) begin
      n_chk++;
      if ({red, green, blue} !== exp_rgb) begin
        n_fail++;
        $display("FAIL rgb_cycle t=%0t col=%0d row=%0d: got %06h expected %06h",
                 $time, col, row, {red, green, blue}, exp_rgb);
      end
    end
  end

  task automatic chk(string name, int act, int expv);
    n_chk++;
    if (act != expv) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, expv);
    end
  endtask

  // Random pixel, biased onto the edges of a model square
  task automatic drive_rand();
    int k, c, r;
    k = $urandom_range(0, N_OBJ - 1);
    case ($urandom_range(0, 4))
      0: c = mx[k] - 1;
      1: c = mx[k];
      2: c = mx[k] + OBJ_SIZE - 1;
      3: c = mx[k] + OBJ_SIZE;
      default: c = $urandom_range(0, 700);
    endcase
    case ($urandom_range(0, 4))
      0: r = my[k] - 1;
      1: r = my[k];
      2: r = my[k] + OBJ_SIZE - 1;
      3: r = my[k] + OBJ_SIZE;
      default: r = $urandom_range(0, 511);
    endcase
    col = 10'(c);
    row = 9'(r);
    disp_ena = ($urandom_range(0, 9) != 0);
  endtask

  task automatic cyc();
    @(negedge clk);
    drive_rand();
  endtask

  task automatic ticks(int n);
    int t0, b;
    t0 = mticks;
    b = 0;
    while (mticks < t0 + n && b < n * TICK_DIV + 8) begin
      cyc();
      b++;
    end
    if (mticks < t0 + n) chk("tick_timeout", mticks, t0 + n);
  endtask

  task automatic move_to(int obj, int tx);
    int b;
    b = 0;
    SW = 3'(obj);
    while (mx[obj] != tx && b < 4000) begin
      KEY = (tx > mx[obj]) ? 4'b1110 : 4'b1101;
      cyc();
      b++;
    end
    KEY = 4'hF;
    chk("move_to", mx[obj], tx);
  endtask

  task automatic probe(string name, int c, int r, bit d, int expv);
    @(negedge clk);
    col = 10'(c);
    row = 9'(r);
    disp_ena = d;
    @(negedge clk);
    chk(name, int'({red, green, blue}), expv);
  endtask

  initial begin
    reset_n = 1'b0; col = '0; row = '0; disp_ena = 1'b0; SW = 3'b000; KEY = 4'hF;
    repeat (3) @(negedge clk);
    chk("reset_rgb", int'({red, green, blue}), 0);
    chk("reset_x0", mx[0], 20);
    chk("reset_x1", mx[1], 90);

    // ten ticks of obj0 moving right, released mid-cycle
    KEY = 4'b1110;
    #2 reset_n = 1'b1;
    chk_en = 1'b1;
    repeat (10 * TICK_DIV) cyc();
    KEY = 4'hF;
    chk("man_x0", mx[0], 40);
    chk("man_y0", my[0], 150);
    chk("man_x1", mx[1], 90);
    probe("pix_sel", 40, 150, 1'b1, 24'hFFFFFF);
    probe("pix_left_bg", 39, 150, 1'b1, 24'h0000FF);
    probe("pix_obj1", 90, 150, 1'b1, 24'h00FF00);

    // right wall clamp and cancelling buttons
    move_to(0, 588);
    KEY = 4'b1110; ticks(3); KEY = 4'hF;
    chk("clamp_x0", mx[0], 590);
    probe("pix_wall", 590, 150, 1'b1, 24'hFFFFFF);
    probe("pix_wall_bg", 589, 150, 1'b1, 24'h0000FF);
    KEY = 4'b1100; ticks(3);
    chk("both_lr_590", mx[0], 590);
    KEY = 4'b1101; ticks(2);
    chk("left_586", mx[0], 586);
    KEY = 4'b1100; ticks(3); KEY = 4'hF;
    chk("both_lr_586", mx[0], 586);

    // bounce off the right wall
    SW = 3'b100; KEY = 4'h0;
    ticks(2);
    chk("bnc_x0", mx[0], 590);
    chk("bnc_dx0", int'(mdx[0]), 0);
    ticks(1);
    chk("bnc_back", mx[0], 588);
    chk("bnc_y0", my[0], 156);

    // overlap, lowest index wins
    move_to(0, 100);
    move_to(1, 100);
    SW = 3'b001;
    probe("ovl_pri", 100, 160, 1'b1, 24'hFF0000);
    probe("ovl_blank", 100, 160, 1'b0, 24'h000000);
    SW = 3'b000;
    probe("ovl_sel0", 100, 160, 1'b1, 24'hFFFFFF);

    // out-of-range selector moves nothing
    SW = 3'b011; KEY = 4'h0;
    ticks(5);
    chk("nosel_x0", mx[0], 100);
    chk("nosel_x1", mx[1], 100);
    chk("nosel_y0", my[0], 156);

    // asynchronous reset mid-motion
    SW = 3'b100;
    repeat (30) cyc();
    @(negedge clk);
    col = 10'd20; row = 9'd150; disp_ena = 1'b1;
    #2 reset_n = 1'b0;
    #1 chk("async_rst_rgb", int'({red, green, blue}), 0);
    @(negedge clk);
    #2 reset_n = 1'b1;
    chk("rst_x0", mx[0], 20);
    chk("rst_y0", my[0], 150);
    for (int k = 1; k <= 5; k++) begin
      @(negedge clk);
      if (k == 3) chk("rst_nomove", int'({red, green, blue}), 24'hFF0000);
      if (k == 4) chk("rst_lastold", int'({red, green, blue}), 24'hFF0000);
      if (k == 5) chk("rst_firstmove", int'({red, green, blue}), 24'h0000FF);
    end

    // random mode/selector/button soup
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(0, 15) == 0) SW = 3'($urandom_range(0, 7));
      KEY = 4'($urandom_range(0, 15));
      cyc();
    end

    chk_en = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
